msrv32_dmem_ctrl: RTL and testbench

Data-memory access controller that sits directly upstream of the load unit. It accepts one load or store request at a time from the execute stage and checks alignment. It drives a pipelined AHB-lite-style data bus (address phase, then data phase, both with wait states) and presents the registered read data, error response and access attributes to the load unit. It stalls the pipeline while an access is in flight.

---
 rtl/msrv32_dmem_ctrl_if.sv | 34 +++
 rtl/msrv32_dmem_ctrl.sv | 132 +++++++++++++
 tb/tb_msrv32_dmem_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/msrv32_dmem_ctrl_if.sv
// Data-side bus between the memory access controller and the AHB-lite-style data port.
// The controller drives the address phase and the memory side returns hready, hresp and read data.
interface msrv32_dmem_ctrl_if;
  logic [31:0] ms_riscv32_mp_dmaddr_out;
  logic [31:0] ms_riscv32_mp_dmdata_out;
  logic [3:0]  ms_riscv32_mp_dmwr_mask_out;
  logic        ms_riscv32_mp_dmwr_req_out;
  logic        ms_riscv32_mp_dmrd_req_out;
  logic        ms_riscv32_mp_data_hready_in;
  logic        ms_riscv32_mp_data_hresp_in;
  logic [31:0] ms_riscv32_mp_dmdata_in;

  modport master (
    output ms_riscv32_mp_dmaddr_out,
    output ms_riscv32_mp_dmdata_out,
    output ms_riscv32_mp_dmwr_mask_out,
    output ms_riscv32_mp_dmwr_req_out,
    output ms_riscv32_mp_dmrd_req_out,
    input  ms_riscv32_mp_data_hready_in,
    input  ms_riscv32_mp_data_hresp_in,
    input  ms_riscv32_mp_dmdata_in
  );

  modport slave (
    input  ms_riscv32_mp_dmaddr_out,
    input  ms_riscv32_mp_dmdata_out,
    input  ms_riscv32_mp_dmwr_mask_out,
    input  ms_riscv32_mp_dmwr_req_out,
    input  ms_riscv32_mp_dmrd_req_out,
    output ms_riscv32_mp_data_hready_in,
    output ms_riscv32_mp_data_hresp_in,
    output ms_riscv32_mp_dmdata_in
  );
endinterface

// File: rtl/msrv32_dmem_ctrl.sv
// Single-outstanding load/store controller: alignment check, pipelined bus access with wait
// states, and registered read data / response / attributes for the downstream load unit.
module msrv32_dmem_ctrl (
  input  logic                       ms_riscv32_mp_clk_in,
  input  logic                       ms_riscv32_mp_rst_in,
  input  logic                       req_valid_in,
  output logic                       req_ready_out,
  input  logic                       req_write_in,
  input  logic [31:0]                req_addr_in,
  input  logic [31:0]                req_wdata_in,
  input  logic [1:0]                 req_size_in,
  input  logic                       req_unsigned_in,
  msrv32_dmem_ctrl_if.master         dbus,
  output logic [31:0]                lu_dmdata_out,
  output logic                       lu_ahb_resp_out,
  output logic [1:0]                 lu_addr_1_to_0_out,
  output logic [1:0]                 lu_load_size_out,
  output logic                       lu_load_unsigned_out,
  output logic                       access_done_out,
  output logic                       misaligned_out,
  output logic                       stall_out
);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, DONE, MISAL} state_t;

  state_t      state;
  logic        write_reg;
  logic        misaligned;
  logic [3:0]  fmt_mask;
  logic [31:0] fmt_wdata;

  // Lane formatting: store data is replicated across lanes, the strobes pick the target bytes.
  always_comb begin
    misaligned = 1'b0;
    fmt_mask   = 4'b1111;
    fmt_wdata  = req_wdata_in;
    case (req_size_in)
      2'b00: begin
        fmt_mask  = 4'b0001 << req_addr_in[1:0];
        fmt_wdata = {4{req_wdata_in[7:0]}};
      end
      2'b01: begin
        misaligned = req_addr_in[0];
        fmt_mask   = req_addr_in[1] ? 4'b1100 : 4'b0011;
        fmt_wdata  = {2{req_wdata_in[15:0]}};
      end
      default: begin
        misaligned = |req_addr_in[1:0];
      end
    endcase
    if (!req_write_in) fmt_mask = 4'b0000;
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      state                            <= IDLE;
      write_reg                        <= 1'b0;
      req_ready_out                    <= 1'b1;
      stall_out                        <= 1'b0;
      access_done_out                  <= 1'b0;
      misaligned_out                   <= 1'b0;
      dbus.ms_riscv32_mp_dmaddr_out    <= 32'h0;
      dbus.ms_riscv32_mp_dmdata_out    <= 32'h0;
      dbus.ms_riscv32_mp_dmwr_mask_out <= 4'h0;
      dbus.ms_riscv32_mp_dmwr_req_out  <= 1'b0;
      dbus.ms_riscv32_mp_dmrd_req_out  <= 1'b0;
      lu_dmdata_out                    <= 32'h0;
      lu_ahb_resp_out                  <= 1'b0;
      lu_addr_1_to_0_out               <= 2'b00;
      lu_load_size_out                 <= 2'b00;
      lu_load_unsigned_out             <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_in) begin
            write_reg            <= req_write_in;
            lu_addr_1_to_0_out   <= req_addr_in[1:0];
            lu_load_size_out     <= req_size_in;
            lu_load_unsigned_out <= req_unsigned_in;
            req_ready_out        <= 1'b0;
            stall_out            <= 1'b1;
            if (misaligned) begin
              // Rejected accesses never touch the bus.
              misaligned_out <= 1'b1;
              state          <= MISAL;
            end else begin
              dbus.ms_riscv32_mp_dmaddr_out    <= {req_addr_in[31:2], 2'b00};
              dbus.ms_riscv32_mp_dmdata_out    <= fmt_wdata;
              dbus.ms_riscv32_mp_dmwr_mask_out <= fmt_mask;
              dbus.ms_riscv32_mp_dmwr_req_out  <= req_write_in;
              dbus.ms_riscv32_mp_dmrd_req_out  <= !req_write_in;
              state                            <= ADDR;
            end
          end
        end
        ADDR: begin
          if (dbus.ms_riscv32_mp_data_hready_in) begin
            dbus.ms_riscv32_mp_dmwr_req_out <= 1'b0;
            dbus.ms_riscv32_mp_dmrd_req_out <= 1'b0;
            state                           <= DATA;
          end
        end
        DATA: begin
          if (dbus.ms_riscv32_mp_data_hready_in) begin
            if (!write_reg) lu_dmdata_out <= dbus.ms_riscv32_mp_dmdata_in;
            lu_ahb_resp_out <= dbus.ms_riscv32_mp_data_hresp_in;
            access_done_out <= 1'b1;
            state           <= DONE;
          end
        end
        DONE: begin
          access_done_out <= 1'b0;
          req_ready_out   <= 1'b1;
          stall_out       <= 1'b0;
          state           <= IDLE;
        end
        MISAL: begin
          misaligned_out <= 1'b0;
          req_ready_out  <= 1'b1;
          stall_out      <= 1'b0;
          state          <= IDLE;
        end
        default: begin
          state          <= IDLE;
          req_ready_out  <= 1'b1;
          stall_out      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msrv32_dmem_ctrl.sv
// Directed bench for msrv32_dmem_ctrl: the bus side is driven step by step from the stimulus,
// and each observation is compared against a hand-computed value.
module tb_msrv32_dmem_ctrl;
  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] lu_dmdata;
  logic        lu_resp;
  logic [1:0]  lu_addr;
  logic [1:0]  lu_size;
  logic        lu_uns;
  logic        done;
  logic        misal;
  logic        stall;

  int checks = 0;
  int failures = 0;

  msrv32_dmem_ctrl_if bus ();

  msrv32_dmem_ctrl dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst_n),
    .req_valid_in         (req_valid),
    .req_ready_out        (req_ready),
    .req_write_in         (req_write),
    .req_addr_in          (req_addr),
    .req_wdata_in         (req_wdata),
    .req_size_in          (req_size),
    .req_unsigned_in      (req_unsigned),
    .dbus                 (bus.master),
    .lu_dmdata_out        (lu_dmdata),
    .lu_ahb_resp_out      (lu_resp),
    .lu_addr_1_to_0_out   (lu_addr),
    .lu_load_size_out     (lu_size),
    .lu_load_unsigned_out (lu_uns),
    .access_done_out      (done),
    .misaligned_out       (misal),
    .stall_out            (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one request for exactly one accept edge, then leaves the caller in cycle E+1.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s, input logic u);
    req_valid    = 1'b1;
    req_write    = w;
    req_addr     = a;
    req_wdata    = d;
    req_size     = s;
    req_unsigned = u;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    logic [3:0]  hr_pat;
    int          done_at;
    int          wr_cycles;
    logic        held_ok;

    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    req_size = 2'b00; req_unsigned = 1'b0;
    bus.ms_riscv32_mp_data_hready_in = 1'b1;
    bus.ms_riscv32_mp_data_hresp_in  = 1'b0;
    bus.ms_riscv32_mp_dmdata_in      = 32'h0;
    tick(); tick();

    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_addr", bus.ms_riscv32_mp_dmaddr_out, 32'h0);
    chk("rst_req", {30'h0, bus.ms_riscv32_mp_dmrd_req_out, bus.ms_riscv32_mp_dmwr_req_out}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Load word at 0x1004, no wait states.
    bus.ms_riscv32_mp_dmdata_in = 32'hDEADBEEF;
    issue(1'b0, 32'h0000_1004, 32'h0, 2'b10, 1'b0);
    chk("lw_rd_req", {31'h0, bus.ms_riscv32_mp_dmrd_req_out}, 32'h1);
    chk("lw_wr_req", {31'h0, bus.ms_riscv32_mp_dmwr_req_out}, 32'h0);
    chk("lw_addr", bus.ms_riscv32_mp_dmaddr_out, 32'h0000_1004);
    chk("lw_mask", {28'h0, bus.ms_riscv32_mp_dmwr_mask_out}, 32'h0);
    chk("lw_ready", {31'h0, req_ready}, 32'h0);
    chk("lw_stall", {31'h0, stall}, 32'h1);
    chk("lw_size", {30'h0, lu_size}, 32'h2);
    tick();
    chk("lw_rd_drop", {31'h0, bus.ms_riscv32_mp_dmrd_req_out}, 32'h0);
    chk("lw_no_early_done", {31'h0, done}, 32'h0);
    tick();
    chk("lw_done", {31'h0, done}, 32'h1);
    chk("lw_data", lu_dmdata, 32'hDEADBEEF);
    chk("lw_resp", {31'h0, lu_resp}, 32'h0);
    tick();
    chk("lw_idle_ready", {31'h0, req_ready}, 32'h1);
    chk("lw_idle_done", {31'h0, done}, 32'h0);
    chk("lw_idle_stall", {31'h0, stall}, 32'h0);

    // Store byte 0xA5 to 0x2003.
    bus.ms_riscv32_mp_dmdata_in = 32'h0BAD_0BAD;
    issue(1'b1, 32'h0000_2003, 32'h0000_00A5, 2'b00, 1'b0);
    chk("sb_wr_req", {31'h0, bus.ms_riscv32_mp_dmwr_req_out}, 32'h1);
    chk("sb_rd_req", {31'h0, bus.ms_riscv32_mp_dmrd_req_out}, 32'h0);
    chk("sb_addr", bus.ms_riscv32_mp_dmaddr_out, 32'h0000_2000);
    chk("sb_mask", {28'h0, bus.ms_riscv32_mp_dmwr_mask_out}, 32'h8);
    chk("sb_data", bus.ms_riscv32_mp_dmdata_out, 32'hA5A5A5A5);
    tick(); tick();
    chk("sb_done", {31'h0, done}, 32'h1);
    chk("sb_lu_data_kept", lu_dmdata, 32'hDEADBEEF);
    tick();

    // Store half 0x1234 to 0x3002: 2 ADDR waits, 3 DATA waits, done expected at accept+8.
    bus.ms_riscv32_mp_data_hready_in = 1'b0;
    issue(1'b1, 32'h0000_3002, 32'hFFFF_1234, 2'b01, 1'b0);
    chk("sh_mask", {28'h0, bus.ms_riscv32_mp_dmwr_mask_out}, 32'hC);
    chk("sh_addr", bus.ms_riscv32_mp_dmaddr_out, 32'h0000_3000);
    done_at = 0;
    wr_cycles = 0;
    held_ok = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      if (done) begin
        done_at = k;
        break;
      end
      if (bus.ms_riscv32_mp_dmwr_req_out) wr_cycles++;
      if (bus.ms_riscv32_mp_dmdata_out !== 32'h12341234 ||
          bus.ms_riscv32_mp_dmwr_mask_out !== 4'hC ||
          bus.ms_riscv32_mp_dmaddr_out !== 32'h0000_3000) held_ok = 1'b0;
      case (k)
        1, 2, 4, 5, 6: hr_pat = 4'h0;
        default:       hr_pat = 4'h1;
      endcase
      bus.ms_riscv32_mp_data_hready_in = hr_pat[0];
      tick();
    end
    chk("sh_done_cycle", done_at, 32'd8);
    chk("sh_wr_cycles", wr_cycles, 32'd3);
    chk("sh_bus_held", {31'h0, held_ok}, 32'h1);
    bus.ms_riscv32_mp_data_hready_in = 1'b1;
    tick();

    // Misaligned load half at 0x1.
    issue(1'b0, 32'h0000_0001, 32'h0, 2'b01, 1'b0);
    chk("mis_pulse", {31'h0, misal}, 32'h1);
    chk("mis_no_req", {30'h0, bus.ms_riscv32_mp_dmrd_req_out, bus.ms_riscv32_mp_dmwr_req_out}, 32'h0);
    chk("mis_stall", {31'h0, stall}, 32'h1);
    chk("mis_done", {31'h0, done}, 32'h0);
    tick();
    chk("mis_back_idle", {31'h0, req_ready}, 32'h1);
    chk("mis_pulse_end", {31'h0, misal}, 32'h0);
    chk("mis_no_req2", {30'h0, bus.ms_riscv32_mp_dmrd_req_out, bus.ms_riscv32_mp_dmwr_req_out}, 32'h0);

    // Load byte unsigned at 0x3 with an error response, then back-to-back load word at 0x40.
    bus.ms_riscv32_mp_dmdata_in = 32'h11223344;
    issue(1'b0, 32'h0000_0003, 32'h0, 2'b00, 1'b1);
    chk("lb_addr_lo", {30'h0, lu_addr}, 32'h3);
    chk("lb_uns", {31'h0, lu_uns}, 32'h1);
    chk("lb_addr", bus.ms_riscv32_mp_dmaddr_out, 32'h0);
    tick();
    bus.ms_riscv32_mp_data_hresp_in = 1'b1;
    tick();
    bus.ms_riscv32_mp_data_hresp_in = 1'b0;
    chk("lb_done", {31'h0, done}, 32'h1);
    chk("lb_resp", {31'h0, lu_resp}, 32'h1);
    chk("lb_data", lu_dmdata, 32'h11223344);
    tick();
    bus.ms_riscv32_mp_dmdata_in = 32'hCAFEF00D;
    chk("b2b_ready", {31'h0, req_ready}, 32'h1);
    issue(1'b0, 32'h0000_0040, 32'h0, 2'b10, 1'b0);
    chk("b2b_rd_req", {31'h0, bus.ms_riscv32_mp_dmrd_req_out}, 32'h1);
    chk("b2b_addr", bus.ms_riscv32_mp_dmaddr_out, 32'h0000_0040);
    chk("b2b_addr_lo", {30'h0, lu_addr}, 32'h0);
    tick(); tick();
    chk("b2b_done", {31'h0, done}, 32'h1);
    chk("b2b_data", lu_dmdata, 32'hCAFEF00D);
    chk("b2b_resp", {31'h0, lu_resp}, 32'h0);
    tick();

    // Store word, then reset while the data phase is waiting.
    issue(1'b1, 32'h0000_0080, 32'h55AA_55AA, 2'b11, 1'b0);
    chk("sw_mask", {28'h0, bus.ms_riscv32_mp_dmwr_mask_out}, 32'hF);
    chk("sw_data", bus.ms_riscv32_mp_dmdata_out, 32'h55AA55AA);
    tick();
    bus.ms_riscv32_mp_data_hready_in = 1'b0;
    tick();
    chk("sw_wait_stall", {31'h0, stall}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("ar_ready", {31'h0, req_ready}, 32'h1);
    chk("ar_stall", {31'h0, stall}, 32'h0);
    chk("ar_addr", bus.ms_riscv32_mp_dmaddr_out, 32'h0);
    chk("ar_data", bus.ms_riscv32_mp_dmdata_out, 32'h0);
    chk("ar_mask", {28'h0, bus.ms_riscv32_mp_dmwr_mask_out}, 32'h0);
    chk("ar_lu_data", lu_dmdata, 32'h0);
    chk("ar_lu_attr", {27'h0, lu_addr, lu_size, lu_uns}, 32'h0);
    bus.ms_riscv32_mp_data_hready_in = 1'b1;
    tick();
    chk("ar_done_held", {31'h0, done}, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("ar_post_ready", {31'h0, req_ready}, 32'h1);
    chk("ar_post_done", {31'h0, done}, 32'h0);
    chk("ar_post_stall", {31'h0, stall}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
